lp805x_rand_core: RTL and testbench

LP805X_RAND_CORE -- requirements
Module: lp805x_rand_core

---
 rtl/lp805x_rand_core_if.sv | 23 ++
 rtl/lp805x_rand_core.sv | 124 ++++++++++++
 tb/tb_lp805x_rand_core.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lp805x_rand_core_if.sv
// Signal bundle between the random-number core and its host.
// Protocol: the host holds run high to request words.
// valid_o is a one-cycle strobe, and number_o is stable from that strobe until the next one or the next seed load.
// loadseed_i wins over run and aborts any word in flight. There is no ready; the core never stalls the host.
interface lp805x_rand_core_if;
    logic        loadseed_i;
    logic [31:0] seed_i;
    logic        run;
    logic [31:0] number_o;
    logic        busy_o;
    logic        valid_o;
    logic        dbg_state;

    modport slave (
        input  loadseed_i, seed_i, run,
        output number_o, busy_o, valid_o, dbg_state
    );

    modport master (
        output loadseed_i, seed_i, run,
        input  number_o, busy_o, valid_o, dbg_state
    );
endinterface

// File: rtl/lp805x_rand_core.sv
// Galois LFSR random word generator: STEPS shifts per word, seed load with zero-seed substitution.
// All outputs are registered; dbg_state mirrors the FSM (0 = IDLE, 1 = RUN).
module lp805x_rand_core #(
    parameter logic [31:0] POLY     = 32'h80200003,
    parameter int          STEPS    = 8,
    parameter logic [31:0] DEF_SEED = 32'h00000001
) (
    input  logic               clk,
    input  logic               rst,
    lp805x_rand_core_if.slave  bus
);

    localparam int            CW       = $clog2(STEPS) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [31:0]   r_lfsr;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_number;
    logic          r_busy;
    logic          r_valid;

    state_t        w_state_nxt;
    logic [31:0]   w_lfsr_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [31:0]   w_number_nxt;
    logic          w_busy_nxt;
    logic          w_valid_nxt;

    logic [31:0]   w_seed_sel;
    logic [31:0]   w_step_src;
    logic [31:0]   w_stepped;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        if (v[0]) begin
            return (v >> 1) ^ POLY;
        end
        return v >> 1;
    endfunction

    assign w_seed_sel = (bus.seed_i == 32'd0) ? DEF_SEED : bus.seed_i;
    // A zero state would lock the LFSR, so it is replaced with DEF_SEED before stepping.
    assign w_step_src = (r_lfsr == 32'd0) ? DEF_SEED : r_lfsr;
    assign w_stepped  = lfsr_step(w_step_src);

    always_comb begin
        w_state_nxt  = r_state;
        w_lfsr_nxt   = r_lfsr;
        w_cnt_nxt    = r_cnt;
        w_number_nxt = r_number;
        w_busy_nxt   = r_busy;
        w_valid_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.loadseed_i) begin
                    w_lfsr_nxt   = w_seed_sel;
                    w_number_nxt = w_seed_sel;
                end else if (bus.run) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = CNT_LOAD;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.loadseed_i) begin
                    w_state_nxt  = S_IDLE;
                    w_lfsr_nxt   = w_seed_sel;
                    w_number_nxt = w_seed_sel;
                    w_cnt_nxt    = '0;
                    w_busy_nxt   = 1'b0;
                end else begin
                    w_lfsr_nxt = w_stepped;
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end else begin
                        w_number_nxt = w_stepped;
                        w_valid_nxt  = 1'b1;
                        // run is only looked at on word boundaries.
                        if (bus.run) begin
                            w_cnt_nxt = CNT_LOAD;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_lfsr   <= DEF_SEED;
            r_cnt    <= '0;
            r_number <= DEF_SEED;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_number <= w_number_nxt;
            r_busy   <= w_busy_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    assign bus.number_o  = r_number;
    assign bus.busy_o    = r_busy;
    assign bus.valid_o   = r_valid;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_lp805x_rand_core.sv
// Bench for lp805x_rand_core: directed vectors on STEPS=1/2 instances, randomized word/seed/abort traffic on a STEPS=8 instance.
// Expected words come from a word-level model that applies the feedback rule STEPS times.
module tb_lp805x_rand_core;

    localparam logic [31:0] POLY     = 32'h80200003;
    localparam logic [31:0] DEF_SEED = 32'h00000001;
    localparam int          STEPS    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_val;

    lp805x_rand_core_if bus1 ();
    lp805x_rand_core_if bus2 ();
    lp805x_rand_core_if bus8 ();

    lp805x_rand_core #(.POLY(POLY), .STEPS(1), .DEF_SEED(DEF_SEED)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    lp805x_rand_core #(.POLY(POLY), .STEPS(2), .DEF_SEED(DEF_SEED)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    lp805x_rand_core #(.POLY(POLY), .STEPS(STEPS), .DEF_SEED(DEF_SEED)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_step(input logic [31:0] v);
        logic [31:0] fb;
        fb = (v % 2 == 1) ? POLY : 32'd0;
        return (v / 2) ^ fb;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = ref_step(r);
        return r;
    endfunction

    function automatic logic [31:0] ref_seed(input logic [31:0] s);
        return (s == 32'd0) ? DEF_SEED : s;
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.loadseed_i = 1'b0; bus1.seed_i = 32'd0; bus1.run = 1'b0;
        bus2.loadseed_i = 1'b0; bus2.seed_i = 32'd0; bus2.run = 1'b0;
        bus8.loadseed_i = 1'b0; bus8.seed_i = 32'd0; bus8.run = 1'b0;
    endtask

    task automatic dut1_word(input logic [31:0] exp);
        bus1.run = 1'b1;
        tick();
        bus1.run = 1'b0;
        check_eq("s1_busy_start", 32'(bus1.busy_o), 32'd1);
        check_eq("s1_no_early_valid", 32'(bus1.valid_o), 32'd0);
        tick();
        check_eq("s1_valid", 32'(bus1.valid_o), 32'd1);
        check_eq("s1_number", bus1.number_o, exp);
        check_eq("s1_busy_end", 32'(bus1.busy_o), 32'd0);
        tick();
        check_eq("s1_valid_single", 32'(bus1.valid_o), 32'd0);
    endtask

    task automatic dut2_seed_word(input logic [31:0] seed, input logic [31:0] exp);
        int          nb;
        int          nv;
        logic [31:0] last;
        bus2.loadseed_i = 1'b1;
        bus2.seed_i     = seed;
        tick();
        bus2.loadseed_i = 1'b0;
        check_eq("s2_seed_loaded", bus2.number_o, ref_seed(seed));
        check_eq("s2_seed_no_valid", 32'(bus2.valid_o), 32'd0);
        bus2.run = 1'b1;
        tick();
        bus2.run = 1'b0;
        nb = 0; nv = 0; last = 32'd0;
        for (int i = 0; i < 6; i++) begin
            if (bus2.busy_o) nb++;
            if (bus2.valid_o) begin
                nv++;
                last = bus2.number_o;
            end
            tick();
        end
        check_eq("s2_busy_cycles", 32'(nb), 32'd2);
        check_eq("s2_valid_count", 32'(nv), 32'd1);
        check_eq("s2_word", last, exp);
    endtask

    // n back-to-back words with run wiggling randomly inside each word.
    task automatic gen_words(input int n);
        logic [31:0] w;
        logic [31:0] exp;
        w = model_val;
        for (int i = 0; i < n; i++) begin
            w = ref_word(w, STEPS);
            exp_q.push_back(w);
        end
        bus8.run = 1'b1;
        tick();
        check_eq("gen_busy_start", 32'(bus8.busy_o), 32'd1);
        check_eq("gen_state_run", 32'(bus8.dbg_state), 32'd1);
        for (int wd = 0; wd < n; wd++) begin
            for (int c = 1; c <= STEPS; c++) begin
                bus8.run    = (c == STEPS) ? (wd < n - 1) : 1'($urandom_range(0, 1));
                bus8.seed_i = $urandom;
                tick();
                if (c < STEPS) begin
                    check_eq("gen_mid_valid", 32'(bus8.valid_o), 32'd0);
                    check_eq("gen_mid_busy", 32'(bus8.busy_o), 32'd1);
                end else begin
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
                    check_eq("gen_valid", 32'(bus8.valid_o), 32'd1);
                    check_eq("gen_word", bus8.number_o, exp);
                    check_eq("gen_busy_after", 32'(bus8.busy_o), 32'(wd < n - 1));
                    model_val = exp;
                end
            end
        end
        bus8.run = 1'b0;
        tick();
        check_eq("gen_valid_drop", 32'(bus8.valid_o), 32'd0);
        check_eq("gen_hold", bus8.number_o, model_val);
    endtask

    // Start a word, then assert loadseed_i on the c_ab-th shift edge.
    task automatic abort_at(input int c_ab, input logic [31:0] seed, input logic run_val);
        bus8.run = 1'b1;
        tick();
        for (int c = 1; c < c_ab; c++) begin
            bus8.run = 1'($urandom_range(0, 1));
            tick();
            check_eq("abort_pre_valid", 32'(bus8.valid_o), 32'd0);
        end
        bus8.loadseed_i = 1'b1;
        bus8.seed_i     = seed;
        bus8.run        = run_val;
        tick();
        bus8.loadseed_i = 1'b0;
        bus8.run        = 1'b0;
        model_val = ref_seed(seed);
        check_eq("abort_busy", 32'(bus8.busy_o), 32'd0);
        check_eq("abort_valid", 32'(bus8.valid_o), 32'd0);
        check_eq("abort_number", bus8.number_o, model_val);
        tick();
        check_eq("abort_no_late_valid", 32'(bus8.valid_o), 32'd0);
        check_eq("abort_state_idle", 32'(bus8.dbg_state), 32'd0);
    endtask

    task automatic load_seed(input logic [31:0] seed, input logic run_val);
        bus8.loadseed_i = 1'b1;
        bus8.seed_i     = seed;
        bus8.run        = run_val;
        tick();
        bus8.loadseed_i = 1'b0;
        bus8.run        = 1'b0;
        model_val = ref_seed(seed);
        check_eq("load_number", bus8.number_o, model_val);
        check_eq("load_busy", 32'(bus8.busy_o), 32'd0);
        check_eq("load_valid", 32'(bus8.valid_o), 32'd0);
        tick();
        check_eq("load_busy_stays", 32'(bus8.busy_o), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus8.seed_i = $urandom;
            tick();
            check_eq("idle_number", bus8.number_o, model_val);
            check_eq("idle_busy", 32'(bus8.busy_o), 32'd0);
            check_eq("idle_valid", 32'(bus8.valid_o), 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] s;
        int          op;
        idle_inputs();
        model_val = DEF_SEED;

        #1 rst = 1'b0;
        #2;
        check_eq("rst_number", bus8.number_o, DEF_SEED);
        check_eq("rst_busy", 32'(bus8.busy_o), 32'd0);
        check_eq("rst_valid", 32'(bus8.valid_o), 32'd0);
        check_eq("rst_state", 32'(bus8.dbg_state), 32'd0);
        tick();
        tick();

        // First edge after release must already accept run.
        @(negedge clk);
        rst = 1'b1;
        dut1_word(32'h80200003);
        bus1.loadseed_i = 1'b1;
        bus1.seed_i     = 32'd0;
        tick();
        bus1.loadseed_i = 1'b0;
        check_eq("s1_zero_seed", bus1.number_o, DEF_SEED);
        dut1_word(32'h80200003);

        dut2_seed_word(32'h00000001, 32'hC0300002);
        dut2_seed_word(32'h00000000, 32'hC0300002);

        gen_words(5);
        abort_at(5, 32'hDEADBEEF, 1'b1);
        load_seed($urandom, 1'b1);
        idle_cycles(2);
        gen_words(2);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 1) begin
                s = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
                load_seed(s, 1'($urandom_range(0, 1)));
            end else if (op <= 6) begin
                gen_words($urandom_range(1, 4));
            end else if (op == 7) begin
                abort_at($urandom_range(1, STEPS), $urandom, 1'($urandom_range(0, 1)));
            end else if (op == 8) begin
                load_seed($urandom, 1'b1);
            end else begin
                idle_cycles($urandom_range(1, 4));
            end
        end

        // Asynchronous reset between edges in the middle of a word.
        bus8.run = 1'b1;
        tick();
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check_eq("arst_number", bus8.number_o, DEF_SEED);
        check_eq("arst_busy", 32'(bus8.busy_o), 32'd0);
        check_eq("arst_valid", 32'(bus8.valid_o), 32'd0);
        check_eq("arst_state", 32'(bus8.dbg_state), 32'd0);
        bus8.run = 1'b0;
        tick();
        tick();
        #3 rst = 1'b1;
        model_val = DEF_SEED;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("arst_no_valid", 32'(bus8.valid_o), 32'd0);
            check_eq("arst_idle_number", bus8.number_o, DEF_SEED);
        end
        gen_words(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
